// File: rtl/cn_trace_buffer.sv
// Trace buffer for the core's (c, n) outputs: stores only changed pairs, stamped with a
// free-running cycle index, in a show-ahead FIFO; flags large c steps and dropped entries.
module cn_trace_buffer #(
  parameter int DEPTH    = 8,
  parameter int W        = 11,
  parameter int TW       = 16,
  parameter int MAX_STEP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [W-1:0]           c,
  input  logic [W-1:0]           n,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_c,
  output logic [W-1:0]           out_n,
  output logic [TW-1:0]          out_idx,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic                   step_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = W + 1;
  localparam int EW = TW + 2 * W;

  logic [TW-1:0] cyc_q, cyc_d;
  logic          have_prev_q, have_prev_d;
  logic [W-1:0]  prev_c_q, prev_c_d;
  logic [W-1:0]  prev_n_q, prev_n_d;
  logic          step_err_q, step_err_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          push_req;
  logic          pop;
  logic          push_acc;
  logic          push_drop;
  logic [DW-1:0] diff;
  logic [DW-1:0] abs_diff;
  logic [EW-1:0] head;

  assign push_req  = in_valid && (!have_prev_q || (c != prev_c_q) || (n != prev_n_q));
  assign pop       = (level_q != '0) && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push_acc  = push_req && ((level_q < LW'(DEPTH)) || pop);
  assign push_drop = push_req && !push_acc;

  // Extra bit keeps the difference signed without wrapping at the W-bit boundary.
  assign diff     = {1'b0, c} - {1'b0, prev_c_q};
  assign abs_diff = diff[W] ? (~diff + DW'(1)) : diff;

  always_comb begin
    cyc_d       = cyc_q + TW'(1);
    have_prev_d = have_prev_q;
    prev_c_d    = prev_c_q;
    prev_n_d    = prev_n_q;
    step_err_d  = step_err_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;

    if (in_valid) begin
      have_prev_d = 1'b1;
      prev_c_d    = c;
      prev_n_d    = n;
      if (have_prev_q && (abs_diff > DW'(MAX_STEP))) begin
        step_err_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (push_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    unique case ({push_acc, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q       <= '0;
      have_prev_q <= 1'b0;
      prev_c_q    <= '0;
      prev_n_q    <= '0;
      step_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      cyc_q       <= cyc_d;
      have_prev_q <= have_prev_d;
      prev_c_q    <= prev_c_d;
      prev_n_q    <= prev_n_d;
      step_err_q  <= step_err_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= {cyc_q, c, n};
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (level_q != '0);
  assign out_idx   = out_valid ? head[EW-1 -: TW] : '0;
  assign out_c     = out_valid ? head[2*W-1 -: W] : '0;
  assign out_n     = out_valid ? head[W-1:0] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign step_err  = step_err_q;

endmodule
